// File: rtl/int_divider_seq_if.sv
// Operand/result handshake bundle for int_divider_seq: valid/ready in, valid/ready out.
interface int_divider_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div0;
   logic             ovf;

   modport master (
      output in_valid, dividend, divisor, is_signed, out_ready,
      input  in_ready, out_valid, quotient, remainder, div0, ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, is_signed, out_ready,
      output in_ready, out_valid, quotient, remainder, div0, ovf
   );
endinterface

// File: rtl/int_divider_seq.sv
// Multi-cycle radix-2 restoring divider, STEPS_PER_CYCLE quotient bits per clock.
// Define DIV_SIGNED_EN to honour is_signed (two's-complement divide with ovf on MIN / -1).
module int_divider_seq #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned STEPS_PER_CYCLE = 1
) (
   input logic           clk,
   input logic           rst_n,
   int_divider_seq_if.slave bus
);
   localparam int unsigned K     = WIDTH / STEPS_PER_CYCLE;
   localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept, w_b_zero, w_sgn, w_a_neg, w_b_neg, w_ovf_in;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;

   // Working operands; not reset, they are reloaded on every accept.
   logic [WIDTH-1:0] r_rem, r_quo, r_div, r_dividend;
   logic             r_zero_div, r_neg_q, r_neg_r, r_ovf_pend;

   logic [WIDTH-1:0] w_rem_nx, w_quo_nx;
   logic [WIDTH:0]   w_rem_sh, w_diff;
   logic [WIDTH-1:0] w_q_fix, w_r_fix;

   logic [WIDTH-1:0] r_quotient, r_remainder;
   logic             r_div0, r_ovf;

`ifdef DIV_SIGNED_EN
   assign w_sgn    = bus.is_signed;
   assign w_ovf_in = w_sgn & (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.divisor);
`else
   logic w_unused;
   assign w_unused = bus.is_signed;
   assign w_sgn    = 1'b0;
   assign w_ovf_in = 1'b0;
`endif

   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_b_zero = (bus.divisor == '0);
   assign w_a_neg  = w_sgn & bus.dividend[WIDTH-1];
   assign w_b_neg  = w_sgn & bus.divisor[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -bus.dividend : bus.dividend;
   assign w_b_mag  = w_b_neg ? -bus.divisor : bus.divisor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_cnt <= '0;
         end else if (r_state == StCalc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         StIdle: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_state_nx = w_b_zero ? StFix : StCalc;
         end
         StCalc: if (r_cnt == CNT_LAST) w_state_nx = StFix;
         StFix:  w_state_nx = StDone;
         StDone: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_state_nx = StIdle;
         end
         default: w_state_nx = StIdle;
      endcase
   end

   // Dividend bits shift out of r_quo's top while quotient bits shift in at the bottom.
   always_comb begin
      w_rem_nx = r_rem;
      w_quo_nx = r_quo;
      w_rem_sh = '0;
      w_diff   = '0;
      for (int i = 0; i < int'(STEPS_PER_CYCLE); i++) begin
         w_rem_sh = {w_rem_nx, w_quo_nx[WIDTH-1]};
         w_diff   = w_rem_sh - {1'b0, r_div};
         w_quo_nx = {w_quo_nx[WIDTH-2:0], ~w_diff[WIDTH]};
         w_rem_nx = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rem      <= '0;
         r_quo      <= w_a_mag;
         r_div      <= w_b_mag;
         r_dividend <= bus.dividend;
         r_zero_div <= w_b_zero;
         r_neg_q    <= w_a_neg ^ w_b_neg;
         r_neg_r    <= w_a_neg;
         r_ovf_pend <= w_ovf_in;
      end else if (r_state == StCalc) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
      end
   end

   // MIN / -1 needs no special quotient: |MIN| negated wraps back to MIN.
   assign w_q_fix = r_zero_div ? '1 : (r_neg_q ? -r_quo : r_quo);
   assign w_r_fix = r_zero_div ? r_dividend : (r_neg_r ? -r_rem : r_rem);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div0      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (r_state == StFix) begin
         r_quotient  <= w_q_fix;
         r_remainder <= w_r_fix;
         r_div0      <= r_zero_div;
         r_ovf       <= ~r_zero_div & r_ovf_pend;
      end
   end

   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.div0      = r_div0;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_int_divider_seq.sv
// Directed bench for int_divider_seq: 8-bit/1-step and 16-bit/4-step instances.
module tb_int_divider_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   int_divider_seq_if #(.WIDTH(8))  bus8 ();
   int_divider_seq_if #(.WIDTH(16)) bus16 ();

   int_divider_seq #(.WIDTH(8), .STEPS_PER_CYCLE(1)) u_div8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   int_divider_seq #(.WIDTH(16), .STEPS_PER_CYCLE(4)) u_div16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   localparam logic [7:0] VA [4] = '{8'd200, 8'd255, 8'd7, 8'd255};
   localparam logic [7:0] VB [4] = '{8'd7,   8'd16,  8'd9, 8'd255};
   localparam logic [7:0] VQ [4] = '{8'd28,  8'd15,  8'd0, 8'd1};
   localparam logic [7:0] VR [4] = '{8'd4,   8'd15,  8'd7, 8'd0};

   // Launches one 8-bit op, returns result, latency in edges after accept and in_ready after accept.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      output logic [7:0] q, output logic [7:0] r, output logic d0,
                      output logic ov, output int lat, output logic rdy_busy);
      @(negedge clk);
      bus8.dividend  = a;
      bus8.divisor   = b;
      bus8.is_signed = sgn;
      bus8.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      rdy_busy = bus8.in_ready;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      q  = bus8.quotient;
      r  = bus8.remainder;
      d0 = bus8.div0;
      ov = bus8.ovf;
      @(negedge clk);
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output int lat);
      @(negedge clk);
      bus16.dividend = a;
      bus16.divisor  = b;
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      q = bus16.quotient;
      r = bus16.remainder;
      @(negedge clk);
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({bus8.in_ready, bus8.out_valid, bus8.div0, bus8.ovf} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags8: got %b want 1000",
                  {bus8.in_ready, bus8.out_valid, bus8.div0, bus8.ovf});
      end
      checks++;
      if ({bus8.quotient, bus8.remainder} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_result8: got %h want 0000", {bus8.quotient, bus8.remainder});
      end
      checks++;
      if ({bus16.in_ready, bus16.out_valid, bus16.quotient, bus16.remainder} !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL reset_16: got %h want %h",
                  {bus16.in_ready, bus16.out_valid, bus16.quotient, bus16.remainder}, {2'b10, 32'h0});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned();
      logic [7:0] q, r;
      logic d0, ov, rb;
      int lat;
      for (int i = 0; i < 4; i++) begin
         op8(VA[i], VB[i], 1'b0, q, r, d0, ov, lat, rb);
         checks++;
         if (q !== VQ[i]) begin
            errors++;
            $display("FAIL unsigned_q[%0d]: got %0d want %0d", i, q, VQ[i]);
         end
         checks++;
         if (r !== VR[i]) begin
            errors++;
            $display("FAIL unsigned_r[%0d]: got %0d want %0d", i, r, VR[i]);
         end
         checks++;
         if ({d0, ov, rb} !== 3'b000) begin
            errors++;
            $display("FAIL unsigned_flags[%0d]: got %b want 000", i, {d0, ov, rb});
         end
         checks++;
         if (lat !== 9) begin
            errors++;
            $display("FAIL unsigned_latency[%0d]: got %0d want 9", i, lat);
         end
      end
   endtask

   task automatic test_div0();
      logic [7:0] q, r;
      logic d0, ov, rb;
      int lat;
      op8(8'd13, 8'd0, 1'b0, q, r, d0, ov, lat, rb);
      checks++;
      if ({q, r} !== {8'hFF, 8'd13}) begin
         errors++;
         $display("FAIL div0_result: got %h want %h", {q, r}, {8'hFF, 8'd13});
      end
      checks++;
      if ({d0, ov} !== 2'b10) begin
         errors++;
         $display("FAIL div0_flags: got %b want 10", {d0, ov});
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL div0_latency: got %0d want 1", lat);
      end
      checks++;
      if (rb !== 1'b0) begin
         errors++;
         $display("FAIL div0_busy_ready: got %b want 0", rb);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      bus8.dividend  = 8'd50;
      bus8.divisor   = 8'd3;
      bus8.is_signed = 1'b0;
      bus8.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL bp_latency: got %0d want 9", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus8.in_valid = 1'b1;
         bus8.dividend = 8'd9;
         bus8.divisor  = 8'd1;
         @(posedge clk); #1;
         checks++;
         if ({bus8.out_valid, bus8.in_ready, bus8.quotient, bus8.remainder}
             !== {2'b10, 8'd16, 8'd2}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got %h want %h", i,
                     {bus8.out_valid, bus8.in_ready, bus8.quotient, bus8.remainder},
                     {2'b10, 8'd16, 8'd2});
         end
      end
      @(negedge clk);
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      checks++;
      if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: got %b want 01", {bus8.out_valid, bus8.in_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_idle_after: got %b want 01", {bus8.out_valid, bus8.in_ready});
      end
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] q, r;
      logic d0, ov, rb;
      int lat;
      @(negedge clk);
      bus8.dividend = 8'd255;
      bus8.divisor  = 8'd1;
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus8.in_ready, bus8.out_valid, bus8.div0, bus8.ovf, bus8.quotient, bus8.remainder}
          !== {4'b1000, 16'h0}) begin
         errors++;
         $display("FAIL midreset_outputs: got %h want %h",
                  {bus8.in_ready, bus8.out_valid, bus8.div0, bus8.ovf, bus8.quotient,
                   bus8.remainder}, {4'b1000, 16'h0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'd100, 8'd10, 1'b0, q, r, d0, ov, lat, rb);
      checks++;
      if ({q, r, d0} !== {8'd10, 8'd0, 1'b0} || lat !== 9) begin
         errors++;
         $display("FAIL midreset_followup: got q=%0d r=%0d div0=%b lat=%0d want 10 0 0 9",
                  q, r, d0, lat);
      end
   endtask

   task automatic test_signed();
      logic [7:0] sa [4];
      logic [7:0] sb [4];
      logic [7:0] sq [4];
      logic [7:0] sr [4];
      logic       ss [4];
      logic       so [4];
      logic [7:0] q, r;
      logic d0, ov, rb;
      int lat;
      sa = '{8'h9C, 8'h64, 8'h80, 8'h9C};
      sb = '{8'h07, 8'hF9, 8'hFF, 8'h07};
      ss = '{1'b1,  1'b1,  1'b1,  1'b0};
`ifdef DIV_SIGNED_EN
      sq = '{8'hF2, 8'hF2, 8'h80, 8'h16};
      sr = '{8'hFE, 8'h02, 8'h00, 8'h02};
      so = '{1'b0,  1'b0,  1'b1,  1'b0};
`else
      sq = '{8'h16, 8'h00, 8'h00, 8'h16};
      sr = '{8'h02, 8'h64, 8'h80, 8'h02};
      so = '{1'b0,  1'b0,  1'b0,  1'b0};
`endif
      for (int i = 0; i < 4; i++) begin
         op8(sa[i], sb[i], ss[i], q, r, d0, ov, lat, rb);
         checks++;
         if ({q, r} !== {sq[i], sr[i]}) begin
            errors++;
            $display("FAIL signed_result[%0d]: got %h want %h", i, {q, r}, {sq[i], sr[i]});
         end
         checks++;
         if ({ov, d0} !== {so[i], 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL signed_flags[%0d]: got ovf=%b div0=%b lat=%0d want %b 0 9",
                     i, ov, d0, lat, so[i]);
         end
      end
   endtask

   task automatic test_wide();
      logic [15:0] q, r, a, b, eq, er;
      int lat, elat;
      op16(16'd65535, 16'd255, q, r, lat);
      checks++;
      if ({q, r} !== {16'd257, 16'd0}) begin
         errors++;
         $display("FAIL wide_result: got %h want %h", {q, r}, {16'd257, 16'd0});
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL wide_latency: got %0d want 5", lat);
      end
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         eq   = (b == 16'd0) ? 16'hFFFF : a / b;
         er   = (b == 16'd0) ? a : a % b;
         elat = (b == 16'd0) ? 1 : 5;
         op16(a, b, q, r, lat);
         checks++;
         if ({q, r} !== {eq, er} || lat !== elat) begin
            errors++;
            $display("FAIL wide_random[%0d] %0d/%0d: got q=%0d r=%0d lat=%0d want %0d %0d %0d",
                     i, a, b, q, r, lat, eq, er, elat);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus8.in_valid   = 1'b0;
      bus8.out_ready  = 1'b0;
      bus8.dividend   = '0;
      bus8.divisor    = '0;
      bus8.is_signed  = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b0;
      bus16.dividend  = '0;
      bus16.divisor   = '0;
      bus16.is_signed = 1'b0;
      test_reset();
      test_unsigned();
      test_div0();
      test_backpressure();
      test_reset_mid_op();
      test_signed();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
